// File: rtl/rr_mux_n_to_1.sv
// Registered N-to-1 valid/ready multiplexer with fixed-select or round-robin arbitration.
// Optional packet lock (grant held until a channel's last beat) enabled by RR_MUX_PKT_LOCK_EN.
module rr_mux_n_to_1 #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [$clog2(NUM_CH)-1:0] sel,
  input  logic [NUM_CH-1:0]         in_valid,
  input  logic [NUM_CH*WIDTH-1:0]   in_data,
  output logic [NUM_CH-1:0]         in_ready,
`ifdef RR_MUX_PKT_LOCK_EN
  input  logic [NUM_CH-1:0]         in_last,
  output logic                      out_last,
`endif
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  input  logic                      out_ready
);

  localparam int unsigned SEL_W = $clog2(NUM_CH);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

  logic             load;
  logic             xfer;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_ch;
  logic [WIDTH-1:0] grant_data;

`ifdef RR_MUX_PKT_LOCK_EN
  logic             out_last_q, out_last_d;
  logic             lock_q,     lock_d;
  logic [SEL_W-1:0] lock_ch_q,  lock_ch_d;
  logic             grant_last;
`endif

  // A slot opens when the register is empty or drains on this edge.
  assign load = en & (~out_valid_q | out_ready);
  assign xfer = load & grant_valid;

  // Grant selection: locked channel first, then round-robin or fixed select.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
`ifdef RR_MUX_PKT_LOCK_EN
    if (lock_q) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (lock_ch_q == SEL_W'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_ch    = SEL_W'(i);
        end
      end
    end else
`endif
    if (mode) begin
      for (int k = 1; k <= int'(NUM_CH); k++) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (!grant_valid && in_valid[i] && ((int'(rr_ptr_q) + k) % int'(NUM_CH)) == i) begin
            grant_valid = 1'b1;
            grant_ch    = SEL_W'(i);
          end
        end
      end
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_ch    = SEL_W'(i);
        end
      end
    end
  end

  // Data (and last) of the granted channel.
  always_comb begin
    grant_data = '0;
`ifdef RR_MUX_PKT_LOCK_EN
    grant_last = 1'b0;
`endif
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (grant_ch == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
`ifdef RR_MUX_PKT_LOCK_EN
        grant_last = in_last[i];
`endif
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (xfer && !rst) begin
      in_ready = NUM_CH'(1) << grant_ch;
    end
  end

  // Next state of the output register, pointer and lock.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef RR_MUX_PKT_LOCK_EN
    out_last_d  = out_last_q;
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_ch_d    = grant_ch;
      if (mode) begin
        rr_ptr_d = grant_ch;
      end
`ifdef RR_MUX_PKT_LOCK_EN
      out_last_d = grant_last;
      lock_d     = ~grant_last;
      lock_ch_d  = grant_ch;
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
`ifdef RR_MUX_PKT_LOCK_EN
      out_last_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= SEL_W'(NUM_CH - 1);
`ifdef RR_MUX_PKT_LOCK_EN
      out_last_q  <= 1'b0;
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef RR_MUX_PKT_LOCK_EN
      out_last_q  <= out_last_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
`ifdef RR_MUX_PKT_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_rr_mux_n_to_1.sv
// Directed self-checking bench for rr_mux_n_to_1 (WIDTH=8, NUM_CH=4).
module tb_rr_mux_n_to_1;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;
`ifdef RR_MUX_PKT_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  rr_mux_n_to_1 #(.WIDTH(8), .NUM_CH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef RR_MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] ch);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".ch"},    32'(out_ch),    32'(ch));
  endtask

  logic [1:0] rr_exp [10];

  initial begin
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
    rst = 1'b1; en = 1'b1; mode = 1'b0; sel = 2'd0;
    in_valid = 4'hF; in_data = 32'h0; out_ready = 1'b0;
`ifdef RR_MUX_PKT_LOCK_EN
    in_last = 4'h0;
`endif
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check_out("rst", 1'b0, 8'h00, 2'd0);

    // Idle after reset
    rst = 1'b0; in_valid = 4'h0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_in_ready", 32'(in_ready), 32'h0);
      check_out("idle", 1'b0, 8'h00, 2'd0);
    end

    // Fixed select, channel 2
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF;
    in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    settle();
    check("fix_in_ready", 32'(in_ready), 32'h4);
    tick();
    check_out("fix_out", 1'b1, 8'hA5, 2'd2);
    in_valid = 4'b1011;
    settle();
    check("fix_noreq_in_ready", 32'(in_ready), 32'h0);
    tick();
    check_out("fix_drain", 1'b0, 8'h00, 2'd2);

    // Round-robin, all requesting, then channel 1 dropped
    mode = 1'b1; in_valid = 4'hF;
    in_data = {8'h43, 8'h32, 8'h21, 8'h10};
    for (int i = 0; i < 10; i++) begin
      if (i == 6) in_valid = 4'b1101;
      settle();
      check("rr_in_ready", 32'(in_ready), 32'(4'b0001 << rr_exp[i]));
      tick();
      check_out("rr_out", 1'b1, 8'h10 + 8'h11 * 8'(rr_exp[i]), rr_exp[i]);
    end

    // Back-pressure
    in_valid = 4'h0; out_ready = 1'b1;
    tick();
    check("bp_empty", 32'(out_valid), 32'h0);
    in_data = {8'h43, 8'h32, 8'h22, 8'h11};
    in_valid = 4'b0011; out_ready = 1'b0;
    settle();
    check("bp_first_in_ready", 32'(in_ready), 32'h1);
    tick();
    check_out("bp_load", 1'b1, 8'h11, 2'd0);
    in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp_hold_in_ready", 32'(in_ready), 32'h0);
      tick();
      check_out("bp_hold", 1'b1, 8'h11, 2'd0);
    end
    out_ready = 1'b1;
    settle();
    check("bp_release_in_ready", 32'(in_ready), 32'h2);
    tick();
    check_out("bp_replace", 1'b1, 8'h22, 2'd1);

    // Enable gating: held beat drains, no new grant
    in_valid = 4'h0; out_ready = 1'b0;
    tick();
    check_out("en_held", 1'b1, 8'h22, 2'd1);
    en = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    in_data = {8'h43, 8'h32, 8'h21, 8'h10};
    settle();
    check("en_off_in_ready", 32'(in_ready), 32'h0);
    tick();
    check_out("en_drain", 1'b0, 8'h00, 2'd1);
    tick();
    check("en_off_stay", 32'(out_valid), 32'h0);

    // Reset mid-stream; pointer frozen at 1 while disabled, so next is 2
    en = 1'b1; out_ready = 1'b0;
    settle();
    check("pre_rst_in_ready", 32'(in_ready), 32'h4);
    tick();
    check_out("pre_rst_held", 1'b1, 8'h32, 2'd2);
    rst = 1'b1;
    settle();
    check("rst_mid_in_ready", 32'(in_ready), 32'h0);
    tick();
    check_out("rst_mid", 1'b0, 8'h00, 2'd0);
    rst = 1'b0; out_ready = 1'b1;
    settle();
    check("post_rst_in_ready", 32'(in_ready), 32'h1);
    tick();
    check_out("post_rst", 1'b1, 8'h10, 2'd0);

`ifdef RR_MUX_PKT_LOCK_EN
    // Packet lock: ch1 holds the grant for three beats
    in_valid = 4'b0111; in_last = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) in_last = 4'b0010;
      settle();
      check("lock_in_ready", 32'(in_ready), 32'h2);
      tick();
      check_out("lock_out", 1'b1, 8'h21, 2'd1);
      check("lock_last", 32'(out_last), (i == 2) ? 32'h1 : 32'h0);
    end
    in_last = 4'b0000;
    settle();
    check("unlock_in_ready", 32'(in_ready), 32'h4);
    tick();
    check_out("unlock_out", 1'b1, 8'h32, 2'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
